// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - byte FIFO feeding an 8N1 UART serializer
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send_ce,
    input  logic [7:0]                    send_data,
    output logic                          send_busy,
    output logic                          Tx,
    output logic                          tx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              PW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_next;
    logic [15:0]     baud_cnt, baud_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift_reg;
    logic            wr_en, pop, baud_done, tx_next;

    // A write is taken only when the FIFO is not full; a pop in the same
    // cycle does not rescue a write that arrived while full.
    assign wr_en     = send_ce && !send_busy;
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign tx_idle   = (state == IDLE) && (fifo_count == '0);

    // Occupancy after this edge from the write/pop combination.
    always_comb begin
        count_next = fifo_count;
        case ({wr_en, pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase
    end

    // Byte storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= send_data;
        end
    end

    // State, counters, FIFO bookkeeping and the registered serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            Tx         <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            send_busy  <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_next;
            Tx         <= tx_next;
            fifo_count <= count_next;
            send_busy  <= (count_next == FULL);
            if (pop) begin
                shift_reg <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PW'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Frame sequencing: each phase lasts CLKS_PER_BIT cycles; STOP chains
    // straight into the next START when bytes are waiting.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        case (state)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (fifo_count != '0) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = (fifo_count != '0) ? START : IDLE;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pop strobe and the line level to register for the upcoming cycle.
    always_comb begin
        pop = (fifo_count != '0) &&
              ((state == IDLE) || ((state == STOP) && baud_done));
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[bit_next];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int C     = 4;
    localparam int D     = 8;
    localparam int FRAME = 10 * C;

    typedef struct {
        logic [7:0] data;
        int         start;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send_ce = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       send_busy, Tx, tx_idle;
    logic [3:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         free_at = 0;
    logic [7:0] m_q[$];
    sb_t        sb[$];
    logic       samp [FRAME];
    int         mcnt = 0;
    int         start_cyc = 0;

    uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .send_ce    (send_ce),
        .send_data  (send_data),
        .send_busy  (send_busy),
        .Tx         (Tx),
        .tx_idle    (tx_idle),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic ce, input logic [7:0] d);
        send_ce   = ce;
        send_data = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic check_frame();
        logic [7:0] b;
        bit         ok;
        sb_t        e;
        ok = 1'b1;
        for (int s = 0; s < 10; s++)
            for (int j = 0; j < C; j++)
                if (samp[s*C+j] !== samp[s*C]) ok = 1'b0;
        if (samp[0] !== 1'b0 || samp[9*C] !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*C];
        check("frame_shape", int'(ok), 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %02h expected none (cycle %0d)", b, cyc);
        end else begin
            e = sb.pop_front();
            check("frame_data", int'(b), int'(e.data));
            check("frame_start", start_cyc, e.start);
        end
    endtask

    // Reference model: a byte queue plus the cycle at which the serializer
    // is next free; one frame occupies 10*C edges from its pop edge.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_q.delete();
            sb.delete();
            free_at = 0;
        end else begin
            int  cnt_pre;
            bit  acc;
            sb_t e;
            cyc++;
            cnt_pre = m_q.size();
            acc     = send_ce && (cnt_pre < D);
            if (cnt_pre > 0 && cyc >= free_at) begin
                e.data  = m_q.pop_front();
                e.start = cyc;
                sb.push_back(e);
                free_at = cyc + FRAME;
            end
            if (acc) m_q.push_back(send_data);
        end
    end

    // Monitor: status outputs every cycle, and frame capture from Tx.
    initial forever begin
        @(negedge clk);
        check("fifo_count", int'(fifo_count), m_q.size());
        check("send_busy", int'(send_busy), int'(m_q.size() == D));
        check("tx_idle", int'(tx_idle), int'(m_q.size() == 0 && cyc >= free_at));
        if (cyc >= free_at) check("tx_line_idle", int'(Tx), 1);
        if (!rst) begin
            mcnt = 0;
        end else if (mcnt == 0) begin
            if (Tx == 1'b0) begin
                start_cyc = cyc;
                samp[0]   = Tx;
                mcnt      = 1;
            end
        end else begin
            samp[mcnt] = Tx;
            mcnt++;
            if (mcnt == FRAME) begin
                check_frame();
                mcnt = 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;

        step(1'b1, 8'hA5);
        idle(50);

        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        idle(130);

        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h10 + i));
        check("busy_after_ninth", int'(send_busy), 1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hEE);
        check("full_count_held", int'(fifo_count), 8);
        idle(400);

        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) step(1'b1, 8'hEE);
        idle(28);
        step(1'b1, 8'h77);
        check("stop_edge_count", int'(fifo_count), 7);
        idle(400);

        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 3) == 0), 8'($urandom));
        idle(400);

        step(1'b1, 8'h36);
        step(1'b1, 8'h81);
        step(1'b1, 8'h42);
        idle(15);
        check("pre_reset_tx", int'(Tx), 0);
        #1 rst = 1'b0;
        #1;
        check("async_rst_tx", int'(Tx), 1);
        check("async_rst_count", int'(fifo_count), 0);
        check("async_rst_idle", int'(tx_idle), 1);
        check("async_rst_busy", int'(send_busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(100);
        step(1'b1, 8'h5A);
        idle(60);

        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && m_q.size() == 0 && cyc >= free_at) break;
            @(negedge clk);
        end
        check("drained", int'(sb.size() == 0 && m_q.size() == 0 && cyc >= free_at), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning byte FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port send_ce, input, 1 bit: byte-write strobe from the memory/UART controller.
REQ-006 SHALL have port send_data, input, 8 bits: byte to transmit, sampled when send_ce=1.
REQ-007 SHALL have port send_busy, output, 1 bit: FIFO full; the writer must not strobe while high.
REQ-008 SHALL have port Tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port tx_idle, output, 1 bit: FIFO empty and serializer in IDLE.
REQ-010 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: bytes currently queued, excluding the byte being shifted.

Function
REQ-011 SHALL accept a write on a clk edge when send_ce=1 and send_busy=0: store send_data at the write pointer, increment the pointer modulo FIFO_DEPTH, increment fifo_count.
REQ-012 SHALL silently drop a write when send_busy=1, even if a pop occurs on the same edge; FIFO contents and count are unchanged by the dropped write.
REQ-013 SHALL, on a simultaneous accepted write and pop, leave fifo_count unchanged and advance both pointers.
REQ-014 SHALL drive send_busy = (fifo_count == FIFO_DEPTH), registered, so it is valid in the cycle after the filling write.
REQ-015 SHALL implement the serializer FSM with states IDLE, START, DATA, STOP.
REQ-016 SHALL, in IDLE with fifo_count>0, pop the head byte into an 8-bit shift register and enter START on that edge.
REQ-017 SHALL drive Tx=0 for exactly CLKS_PER_BIT cycles in START.
REQ-018 SHALL, in DATA, drive 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, counted by a 3-bit bit index.
REQ-019 SHALL drive Tx=1 for exactly CLKS_PER_BIT cycles in STOP.
REQ-020 SHALL, at the end of STOP, pop directly into START with no idle gap if fifo_count>0, else enter IDLE.
REQ-021 SHALL register Tx so it is glitch-free; frame length is 10*CLKS_PER_BIT cycles.
REQ-022 SHALL set latency so a write to an empty FIFO in IDLE on edge N causes the pop on edge N+1, with Tx low from edge N+1.
REQ-023 SHALL drive tx_idle=1 only when state is IDLE and fifo_count=0.
REQ-024 SHALL not change the serialized frame when send_data or send_ce changes mid-frame.

Reset
REQ-025 SHALL, while rst=0 and independent of clk, force Tx=1, send_busy=0, tx_idle=1, fifo_count=0, both pointers=0, state=IDLE, baud counter=0 and bit index=0.
REQ-026 SHALL, on reset asserted mid-frame, abort the frame immediately with Tx high and discard all queued bytes.
REQ-027 SHALL accept the first write on the first rising clk edge after rst deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-028 SHALL cover: reset release, one write of 0xA5 -> Tx low cycles 1-4, then bits 1,0,1,0,0,1,0,1 four cycles each, high cycles 37-40, tx_idle=1 from cycle 41.
REQ-029 SHALL cover: 3 writes 0x01,0x02,0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; fifo_count peaks at 2.
REQ-030 SHALL cover: 9 back-to-back writes 0x10..0x18 starting while IDLE -> first byte popped after one cycle, send_busy=1 after the ninth write, no byte dropped, 9 frames in order.
REQ-031 SHALL cover: fill to 8 while a frame shifts, then write 0xEE while send_busy=1 -> 0xEE never appears on Tx, fifo_count stays 8.
REQ-032 SHALL cover: rst pulsed low during DATA bit 3 -> Tx=1, fifo_count=0, tx_idle=1 asynchronously; no residual frame after release.
REQ-033 SHALL cover: write on the same edge STOP ends with fifo_count=8 -> pop proceeds, write dropped, fifo_count=7.
